uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx_pkg.sv | 34 +++
 rtl/uart_frame_rx_buf.sv | 31 +++
 rtl/uart_frame_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_rx_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_frame_rx_pkg : shared framing constants for the UART RX/TX framers   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_frame_rx_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_LEN = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int LEN_W = 5;
  localparam int TMO_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Checksum is a plain XOR over LEN and every payload byte.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_rx_buf.sv
// +--------------------------------------------------------------------------+
// | uart_frame_buf : MAX_LEN x 8 payload store, 1 write port, async read      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_frame_rx.sv
// +--------------------------------------------------------------------------+
// | uart_frame_rx : SOF/LEN/payload/CSUM frame parser with buffered drain     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50,
  parameter int TIMEOUT_US    = 1000,
  parameter int MAX_LEN       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  output logic             rx_data_ready,
  output logic [7:0]       pl_data,
  output logic             pl_valid,
  output logic             pl_last,
  input  logic             pl_ready,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]       c_max_len   = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] c_tmo_limit = TMO_W'(CLK_FREQUENCY * TIMEOUT_US - 1);

  state_t           r_state, w_state;
  logic [LEN_W-1:0] r_len, w_len;
  logic [LEN_W-1:0] r_wr_idx, w_wr_idx;
  logic [LEN_W-1:0] r_rd_idx, w_rd_idx;
  logic [7:0]       r_xor, w_xor;
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic             r_frame_ok, w_frame_ok;
  logic             r_frame_err, w_frame_err;
  logic [1:0]       r_err_code, w_err_code;
  logic [LEN_W-1:0] r_frame_len, w_frame_len;

  logic             w_accept;
  logic             w_counting;
  logic             w_tmo_hit;
  logic             w_buf_we;
  logic [7:0]       w_rd_data;

  assign w_accept   = rx_data_valid && rx_data_ready;
  assign w_counting = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
  assign w_tmo_hit  = w_counting && (r_tmo == c_tmo_limit);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (w_buf_we),
    .wr_addr (r_wr_idx[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (r_rd_idx[AW-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_xor       <= '0;
      r_tmo       <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_frame_len <= '0;
    end else begin
      r_state     <= w_state;
      r_len       <= w_len;
      r_wr_idx    <= w_wr_idx;
      r_rd_idx    <= w_rd_idx;
      r_xor       <= w_xor;
      r_tmo       <= w_tmo;
      r_frame_ok  <= w_frame_ok;
      r_frame_err <= w_frame_err;
      r_err_code  <= w_err_code;
      r_frame_len <= w_frame_len;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_len       = r_len;
    w_wr_idx    = r_wr_idx;
    w_rd_idx    = r_rd_idx;
    w_xor       = r_xor;
    w_tmo       = w_counting ? (r_tmo + TMO_W'(1)) : '0;
    w_frame_ok  = 1'b0;
    w_frame_err = 1'b0;
    w_err_code  = r_err_code;
    w_frame_len = r_frame_len;
    w_buf_we    = 1'b0;

    // A stalled sender loses the frame even if a byte lands on the same edge.
    if (w_tmo_hit) begin
      w_frame_err = 1'b1;
      w_err_code  = ERR_TIMEOUT;
      w_state     = ST_IDLE;
      w_tmo       = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (rx_data == SOF_BYTE)) begin
            w_state = ST_LEN;
            w_tmo   = '0;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            w_tmo = '0;
            if ((rx_data == 8'd0) || (rx_data > c_max_len)) begin
              w_frame_err = 1'b1;
              w_err_code  = ERR_BAD_LEN;
              w_state     = ST_IDLE;
            end else begin
              w_len    = rx_data[LEN_W-1:0];
              w_wr_idx = '0;
              w_xor    = rx_data;
              w_state  = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_accept) begin
            w_tmo    = '0;
            w_buf_we = 1'b1;
            w_xor    = csum_fold(r_xor, rx_data);
            w_wr_idx = r_wr_idx + LEN_W'(1);
            if (r_wr_idx == (r_len - LEN_W'(1))) begin
              w_state = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (w_accept) begin
            w_tmo = '0;
            if (rx_data == r_xor) begin
              w_frame_ok  = 1'b1;
              w_frame_len = r_len;
              w_rd_idx    = '0;
              w_state     = ST_DRAIN;
            end else begin
              w_frame_err = 1'b1;
              w_err_code  = ERR_CSUM;
              w_state     = ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (pl_ready) begin
            if (r_rd_idx == (r_len - LEN_W'(1))) begin
              w_state = ST_IDLE;
            end else begin
              w_rd_idx = r_rd_idx + LEN_W'(1);
            end
          end
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data_ready = (r_state != ST_DRAIN);
  assign pl_valid      = (r_state == ST_DRAIN);
  assign pl_last       = pl_valid && (r_rd_idx == (r_len - LEN_W'(1)));
  // Force zero outside DRAIN so the unreset buffer never leaks onto the port.
  assign pl_data       = pl_valid ? w_rd_data : 8'h00;
  assign frame_len     = r_frame_len;
  assign frame_ok      = r_frame_ok;
  assign frame_err     = r_frame_err;
  assign err_code      = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
// +--------------------------------------------------------------------------+
// | tb_uart_frame_rx : scoreboard bench for uart_frame_rx                     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_frame_rx;

  localparam int K_OK   = 1;
  localparam int K_ERR  = 2;
  localparam int K_DATA = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       last;
    logic [4:0] len;
    logic [1:0] code;
  } exp_t;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       rx_data_ready;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_last;
  logic       pl_ready = 1'b0;
  logic [4:0] frame_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_frame_rx #(
    .CLK_FREQUENCY (1),
    .TIMEOUT_US    (10),
    .MAX_LEN       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .pl_data       (pl_data),
    .pl_valid      (pl_valid),
    .pl_last       (pl_last),
    .pl_ready      (pl_ready),
    .frame_len     (frame_len),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int kind, input logic [7:0] data, input logic last,
                          input logic [4:0] len, input logic [1:0] code);
    exp_t e;
    e.kind = kind; e.data = data; e.last = last; e.len = len; e.code = code;
    q.push_back(e);
  endtask

  task automatic sb_compare(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got event kind %0d, expected no event (t=%0t)", kind, $time);
    end else begin
      e = q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      if (kind == e.kind) begin
        case (kind)
          K_OK:    check("ok_frame_len", 32'(frame_len), 32'(e.len));
          K_ERR:   check("err_code", 32'(err_code), 32'(e.code));
          default: begin
            check("pl_data", 32'(pl_data), 32'(e.data));
            check("pl_last", 32'(pl_last), 32'(e.last));
            check("drain_frame_len", 32'(frame_len), 32'(e.len));
          end
        endcase
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports something.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok || frame_err) check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
      if (frame_ok)  sb_compare(K_OK);
      if (frame_err) sb_compare(K_ERR);
      if (pl_valid && pl_ready) sb_compare(K_DATA);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    rx_data       = b;
    rx_data_valid = 1'b1;
    while (!rx_data_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!rx_data_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_wait: rx_data_ready stuck at 0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic count_drain(input string name, input int exp_n);
    int n = 0;
    while (pl_valid && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_data_ready"}, 32'(rx_data_ready), 32'd1);
    check({tag, "_pl_valid"},      32'(pl_valid),      32'd0);
    check({tag, "_pl_last"},       32'(pl_last),       32'd0);
    check({tag, "_pl_data"},       32'(pl_data),       32'd0);
    check({tag, "_frame_ok"},      32'(frame_ok),      32'd0);
    check({tag, "_frame_err"},     32'(frame_err),     32'd0);
    check({tag, "_err_code"},      32'(err_code),      32'd0);
    check({tag, "_frame_len"},     32'(frame_len),     32'd0);
  endtask

  initial begin
    byte_q_t bq;
    int      n;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_outputs("reset");

    // Good 3-byte frame, csum = 03^11^22^33 = 03
    pl_ready = 1'b1;
    push_exp(K_OK,   8'h00, 1'b0, 5'd3, 2'b00);
    push_exp(K_DATA, 8'h11, 1'b0, 5'd3, 2'b00);
    push_exp(K_DATA, 8'h22, 1'b0, 5'd3, 2'b00);
    push_exp(K_DATA, 8'h33, 1'b1, 5'd3, 2'b00);
    bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq(bq);
    count_drain("good_frame_drain_cycles", 3);
    check("good_frame_ready_after", 32'(rx_data_ready), 32'd1);

    // Checksum error: 02^10^20 = 32, sent 31
    push_exp(K_ERR, 8'h00, 1'b0, 5'd0, 2'b10);
    bq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    send_seq(bq);
    repeat (3) @(posedge clk);
    #1;
    check("csum_err_code_held", 32'(err_code), 32'd2);

    // Bad lengths: zero and MAX_LEN+1
    push_exp(K_ERR, 8'h00, 1'b0, 5'd0, 2'b01);
    push_exp(K_ERR, 8'h00, 1'b0, 5'd0, 2'b01);
    bq = '{8'hA5, 8'h00, 8'hA5, 8'h11};
    send_seq(bq);
    repeat (2) @(posedge clk);
    #1;

    // Timeout: frame_err exactly 10 cycles after AA is accepted
    push_exp(K_ERR, 8'h00, 1'b0, 5'd0, 2'b11);
    bq = '{8'hA5, 8'h02, 8'hAA};
    send_seq(bq);
    n = 0;
    while (!frame_err && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_latency", 32'(n), 32'd10);
    check("timeout_err_code", 32'(err_code), 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Noise then 1-byte frame with an A5 payload, csum = 01^A5 = A4, sink stalled
    pl_ready = 1'b0;
    push_exp(K_OK,   8'h00, 1'b0, 5'd1, 2'b00);
    push_exp(K_DATA, 8'hA5, 1'b1, 5'd1, 2'b00);
    bq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'hA4};
    send_seq(bq);
    rx_data       = 8'hA5;
    rx_data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("stall_rx_data_ready", 32'(rx_data_ready), 32'd0);
      check("stall_pl_valid",      32'(pl_valid),      32'd1);
      check("stall_pl_data",       32'(pl_data),       32'hA5);
      check("stall_pl_last",       32'(pl_last),       32'd1);
      @(posedge clk); #1;
    end
    rx_data_valid = 1'b0;
    pl_ready      = 1'b1;
    @(posedge clk); #1;
    check("stall_release_pl_valid", 32'(pl_valid), 32'd0);
    check("stall_release_ready",    32'(rx_data_ready), 32'd1);

    // Reset in the middle of a payload drops the frame silently
    bq = '{8'hA5, 8'h03, 8'h11};
    send_seq(bq);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle_outputs("midreset");

    // Frame after reset, csum = 02^5A^C3 = 9B
    push_exp(K_OK,   8'h00, 1'b0, 5'd2, 2'b00);
    push_exp(K_DATA, 8'h5A, 1'b0, 5'd2, 2'b00);
    push_exp(K_DATA, 8'hC3, 1'b1, 5'd2, 2'b00);
    bq = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    send_seq(bq);
    count_drain("post_reset_drain_cycles", 2);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
